// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access controller: FSM states and bus owner.
package mem_access_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_CAP  = 3'd3,
        ST_RD_OUT  = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_WR_WAIT = 3'd6
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_access_ctrl_arb.sv
// Two-way round-robin arbiter. Bit 0 is fetch, bit 1 is data. With both
// requesting, the one that did not win last time gets the grant. Grants are
// only issued while update_i is high (controller idle).
module rr_arb2
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    // One-hot grant; a lone requester always wins, a tie goes to the non-last owner.
    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = update_i & req_i[0] & (~req_i[1] | (last_i == OWN_DATA));
        gnt_o[1] = update_i & req_i[1] & (~req_i[0] | (last_i == OWN_FETCH));
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates fetch vs. load/store, then sequences
// MAR/MDR strobes and Read/Write for one transaction with a fixed latency.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no transaction; arbitrate between fetch and data requests
// ADDR     | requester drives address, MAR loads it
// RD_WAIT  | Read held for MEM_LAT cycles while memory responds
// RD_CAP   | Read still high, MDR captures memory data
// RD_OUT   | MDR drives the bus, owner's done pulses
// WR_DATA  | store data driven onto bus, MDR loads it
// WR_WAIT  | Write held for MEM_LAT cycles, data_done on the last one
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic fetch_req,
    input  logic data_req,
    input  logic data_we,
    output logic gnt_fetch,
    output logic gnt_data,
    output logic addr_phase,
    output logic wdata_phase,
    output logic MARin,
    output logic MDRin,
    output logic MDRout,
    output logic Read,
    output logic Write,
    output logic fetch_done,
    output logic data_done,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_e           owner_q, owner_d;
    logic             is_store_q, is_store_d;
    owner_e           last_q, last_d;
    logic [1:0]       gnt;

    rr_arb2 u_arb (
        .req_i    ({data_req, fetch_req}),
        .last_i   (last_q),
        .update_i (state_q == ST_IDLE),
        .gnt_o    (gnt)
    );

    // State, latency counter and transaction context registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            owner_q    <= OWN_FETCH;
            is_store_q <= 1'b0;
            last_q     <= OWN_DATA;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            is_store_q <= is_store_d;
            last_q     <= last_d;
        end
    end

    // Next-state, counter and round-robin history update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        is_store_d = is_store_q;
        last_d     = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    owner_d    = gnt[1] ? OWN_DATA : OWN_FETCH;
                    is_store_d = gnt[1] & data_we;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (is_store_q) begin
                    state_d = ST_WR_DATA;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RD_CAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RD_CAP: begin
                state_d = ST_RD_OUT;
            end
            ST_RD_OUT: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            ST_WR_DATA: begin
                cnt_d   = LAT_LOAD;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (cnt_q == '0) begin
                    last_d  = OWN_DATA;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from registered state only.
    always_comb begin
        gnt_fetch   = 1'b0;
        gnt_data    = 1'b0;
        addr_phase  = 1'b0;
        wdata_phase = 1'b0;
        MARin       = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        Read        = 1'b0;
        Write       = 1'b0;
        fetch_done  = 1'b0;
        data_done   = 1'b0;
        busy        = (state_q != ST_IDLE);
        if (state_q != ST_IDLE) begin
            gnt_fetch = (owner_q == OWN_FETCH);
            gnt_data  = (owner_q == OWN_DATA);
        end
        unique case (state_q)
            ST_ADDR: begin
                MARin      = 1'b1;
                addr_phase = 1'b1;
            end
            ST_RD_WAIT: begin
                Read = 1'b1;
            end
            ST_RD_CAP: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            ST_RD_OUT: begin
                MDRout     = 1'b1;
                fetch_done = (owner_q == OWN_FETCH);
                data_done  = (owner_q == OWN_DATA);
            end
            ST_WR_DATA: begin
                wdata_phase = 1'b1;
                MDRin       = 1'b1;
            end
            ST_WR_WAIT: begin
                Write     = 1'b1;
                data_done = (cnt_q == '0);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: random requesters, a small MAR/MDR/memory datapath,
// a transaction-level reference model feeding a scoreboard queue, and a monitor
// that checks every cycle's strobes and pops on each done pulse.
module tb_mem_access_ctrl;

    localparam int LAT = 2;

    logic clk, reset;
    logic fetch_req, data_req, data_we;
    logic gnt_fetch, gnt_data, addr_phase, wdata_phase, MARin, MDRin, MDRout;
    logic Read, Write, fetch_done, data_done, busy;

    logic f1, d1, we1;
    logic gf1, gd1, ap1, wp1, mar1, mdri1, mdro1, rd1, wr1, fd1, dd1, bz1;

    mem_access_ctrl #(.MEM_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .data_req(data_req),
        .data_we(data_we), .gnt_fetch(gnt_fetch), .gnt_data(gnt_data),
        .addr_phase(addr_phase), .wdata_phase(wdata_phase), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
        .fetch_done(fetch_done), .data_done(data_done), .busy(busy)
    );

    mem_access_ctrl #(.MEM_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .fetch_req(f1), .data_req(d1),
        .data_we(we1), .gnt_fetch(gf1), .gnt_data(gd1),
        .addr_phase(ap1), .wdata_phase(wp1), .MARin(mar1),
        .MDRin(mdri1), .MDRout(mdro1), .Read(rd1), .Write(wr1),
        .fetch_done(fd1), .data_done(dd1), .busy(bz1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester-side operands and the environment datapath
    logic [3:0] faddr, daddr, mar;
    logic [7:0] dwdata, mdr, bus;
    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];

    always_comb begin
        bus = 8'h00;
        if (addr_phase)       bus = {4'h0, gnt_data ? daddr : faddr};
        else if (wdata_phase) bus = dwdata;
        else if (MDRout)      bus = mdr;
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[3]     = 8'd23;
        ref_mem[3] = 8'd23;
        mar = '0;
        mdr = '0;
        forever begin
            @(posedge clk);
            if (MARin) mar <= bus[3:0];
            if (MDRin) mdr <= Read ? mem[mar] : bus;
            if (Write) mem[mar] <= mdr;
        end
    end

    // Reference model: one transaction at a time, round-robin on ties.
    typedef struct {
        bit         owner;   // 1 = data
        bit         store;
        int         g;
        int         done;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } txn_t;

    txn_t q[$];
    int   cyc = 0;
    int   free_at = 0;
    bit   last_own = 1'b1;
    bit   started = 1'b0;

    initial begin
        txn_t t;
        forever begin
            @(posedge clk);
            cyc++;
            started = 1'b1;
            if (reset) begin
                q.delete();
                last_own = 1'b1;
                free_at  = cyc + 1;
            end else if (cyc >= free_at && (fetch_req || data_req)) begin
                t.owner = (fetch_req && data_req) ? !last_own : data_req;
                t.store = t.owner && data_we;
                t.g     = cyc;
                t.done  = cyc + (t.store ? LAT + 1 : LAT + 2);
                t.addr  = t.owner ? daddr : faddr;
                t.wdata = dwdata;
                t.rdata = ref_mem[t.addr];
                if (t.store) ref_mem[t.addr] = t.wdata;
                q.push_back(t);
                last_own = t.owner;
                free_at  = t.done + 2;
            end
        end
    end

    // Monitor: per-cycle strobe vector, plus scoreboard pop on done.
    int         st_chk_cyc = -1;
    logic [3:0] st_chk_addr;
    logic [7:0] st_chk_val;

    initial begin
        logic [11:0] exp_v, act_v;
        txn_t t;
        int k;
        bit got_done;
        forever begin
            @(negedge clk);
            if (!started) continue;
            exp_v = '0;
            if (q.size() > 0 && cyc >= q[0].g) begin
                k = cyc - q[0].g;
                exp_v[11] = !q[0].owner;
                exp_v[10] = q[0].owner;
                exp_v[0]  = 1'b1;
                if (k == 0) begin
                    exp_v[9] = 1'b1;
                    exp_v[7] = 1'b1;
                end else if (q[0].store) begin
                    if (k == 1) begin
                        exp_v[8] = 1'b1;
                        exp_v[6] = 1'b1;
                    end else begin
                        exp_v[3] = 1'b1;
                        if (k == LAT + 1) exp_v[1] = 1'b1;
                    end
                end else begin
                    if (k <= LAT) exp_v[4] = 1'b1;
                    else if (k == LAT + 1) begin
                        exp_v[4] = 1'b1;
                        exp_v[6] = 1'b1;
                    end else begin
                        exp_v[5] = 1'b1;
                        if (q[0].owner) exp_v[1] = 1'b1;
                        else            exp_v[2] = 1'b1;
                    end
                end
            end
            act_v = {gnt_fetch, gnt_data, addr_phase, wdata_phase, MARin, MDRin,
                     MDRout, Read, Write, fetch_done, data_done, busy};
            chk($sformatf("strobes@%0d", cyc), 32'(act_v), 32'(exp_v));

            if (cyc == st_chk_cyc) chk("store_commit", 32'(mem[st_chk_addr]), 32'(st_chk_val));

            got_done = fetch_done || data_done;
            if (q.size() > 0 && cyc >= q[0].g && (got_done || cyc >= q[0].done)) begin
                t = q.pop_front();
                chk("done_present", 32'(got_done), 32'd1);
                chk("done_cycle", 32'(cyc), 32'(t.done));
                chk("done_owner", {30'd0, data_done, fetch_done}, t.owner ? 32'd2 : 32'd1);
                if (!t.store) chk("read_data", 32'(bus), 32'(t.rdata));
                else begin
                    st_chk_cyc  = cyc + 1;
                    st_chk_addr = t.addr;
                    st_chk_val  = t.wdata;
                end
            end else if (got_done) begin
                chk("spurious_done", 32'(got_done), 32'd0);
            end
        end
    end

    // Stimulus
    initial begin
        int cnt;
        bit did_rst;
        reset = 1'b1;
        fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b1;
        faddr = 4'd3; daddr = 4'd5; dwdata = 8'd35;
        f1 = 1'b0; d1 = 1'b0; we1 = 1'b0;
        did_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {20'd0, gnt_fetch, gnt_data, addr_phase, wdata_phase, MARin, MDRin,
            MDRout, Read, Write, fetch_done, data_done, busy}, 32'd0);
        #1 reset = 1'b0;

        // first two transactions: fetch from addr 3 (23), then store 35 to addr 5
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            #1;
            if (!did_rst && i > 300 && q.size() > 0 && !q[0].store && cyc == q[0].g + 1) begin
                reset   = 1'b1;
                did_rst = 1'b1;
            end else begin
                reset = 1'b0;
            end
            if (fetch_done) begin
                faddr = 4'($urandom);
                if ($urandom_range(3) != 0) fetch_req = 1'b0;
            end else if (!fetch_req && $urandom_range(2) == 0) begin
                fetch_req = 1'b1;
            end
            if (data_done) begin
                daddr  = 4'($urandom);
                dwdata = 8'($urandom);
                if ($urandom_range(3) != 0) data_req = 1'b0;
            end else if (!data_req && $urandom_range(2) == 0) begin
                data_req = 1'b1;
            end
            if (i > 20) data_we = 1'($urandom);
        end

        // contention: both requests held high continuously
        @(negedge clk);
        #1 reset = 1'b0;
        fetch_req = 1'b1;
        data_req  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            data_we = 1'($urandom);
            if (fetch_done) faddr = 4'($urandom);
            if (data_done) begin
                daddr  = 4'($urandom);
                dwdata = 8'($urandom);
            end
        end

        // drain
        fetch_req = 1'b0;
        data_req  = 1'b0;
        cnt = 0;
        while (q.size() > 0 && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);

        // MEM_LAT=1 instance: read done on the 4th sampled cycle after grant, store on the 3rd
        #1 f1 = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!fd1 && cnt < 20);
        #1 f1 = 1'b0;
        chk("lat1_read_cycles", 32'(cnt), 32'd4);
        @(negedge clk);
        chk("lat1_read_done_width", 32'(fd1), 32'd0);
        repeat (2) @(negedge clk);

        #1 d1 = 1'b1; we1 = 1'b1;
        @(negedge clk);
        #1 we1 = 1'b0;
        cnt = 1;
        while (!dd1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        #1 d1 = 1'b0;
        chk("lat1_store_cycles", 32'(cnt), 32'd3);
        chk("lat1_store_write", 32'(wr1), 32'd1);
        @(negedge clk);
        chk("lat1_store_done_width", 32'(dd1), 32'd0);
        chk("lat1_idle", {29'd0, bz1, rd1, wr1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the memory data register and memory address register for one memory transaction at a time.
- Shares that path between two requesters: instruction fetch and data load/store from the control unit.
- Drives MARin, MDRin, MDRout, Read and Write in the correct cycle order.
- Counts a fixed memory latency and returns a one-cycle done pulse to the granted requester.

Parameters:
- MEM_LAT, 2, memory access latency in clock cycles (legal range 1..15); cycles Read or Write is held before data is valid or committed.
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_req  input  1  instruction fetch request; level, held until fetch_done.
- data_req  input  1  load/store request; level, held until data_done.
- data_we  input  1  1 = store, 0 = load; sampled in the grant cycle only.
- gnt_fetch  output  1  fetch owns the bus path; held from ADDR through DONE.
- gnt_data  output  1  data owns the bus path; held from ADDR through DONE.
- addr_phase  output  1  granted requester must drive the address onto the bus this cycle.
- wdata_phase  output  1  granted store must drive the write data onto the bus this cycle.
- MARin  output  1  load the memory address register from the bus.
- MDRin  output  1  load the memory data register (from Mdata when Read=1, from the bus when Read=0).
- MDRout  output  1  the memory data register drives the bus.
- Read  output  1  memory read strobe; also the MDR input-mux select.
- Write  output  1  memory write strobe.
- fetch_done  output  1  one-cycle pulse: fetch data is on the bus this cycle.
- data_done  output  1  one-cycle pulse: load data is on the bus, or the store has been committed.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, counter=0, last_gnt=data. All outputs are 0.
- Reset is synchronous and takes priority over every transition. A transaction interrupted by reset is abandoned, with no done pulse.
- States: IDLE, ADDR, RD_WAIT, RD_CAP, RD_OUT, WR_DATA, WR_WAIT.
- IDLE, arbitration (round-robin):
  - Only fetch_req high: grant fetch.
  - Only data_req high: grant data.
  - Both high: grant the requester that is not last_gnt.
  - On a grant: latch the owner and latch is_store = data_we & (owner==data). A fetch is always a read. Go to ADDR.
  - No request: stay in IDLE.
- ADDR (1 cycle): MARin=1, addr_phase=1. Next state is WR_DATA if is_store, else RD_WAIT with counter=MEM_LAT-1.
- RD_WAIT: Read=1. Decrement the counter each cycle; at counter==0 go to RD_CAP. The state lasts exactly MEM_LAT cycles.
- RD_CAP (1 cycle): Read=1, MDRin=1. The MDR captures Mdata at the end of the cycle.
- RD_OUT (1 cycle): MDRout=1, and the owner's done=1. Update last_gnt=owner, then go to IDLE.
- WR_DATA (1 cycle): wdata_phase=1, MDRin=1, Read=0. Load counter=MEM_LAT-1, go to WR_WAIT.
- WR_WAIT: Write=1 for exactly MEM_LAT cycles. data_done=1 on the last cycle (counter==0). Update last_gnt=data, then go to IDLE.
- Grant outputs are asserted in every non-IDLE state and are 0 in IDLE.
- The controller never issues back-to-back transactions without an IDLE cycle. Read latency from grant edge to done is MEM_LAT+3 cycles; store latency is MEM_LAT+2.
- Request changes during a transaction are ignored; the transaction always completes. A requester that keeps its request high after done is re-arbitrated in IDLE.
- All outputs are registered-state decodes: Moore outputs, no combinational path from inputs to outputs.
- Mutual exclusion: MARin, MDRout and wdata_phase are never high together. Read and Write are never high together.

Decomposition:
- Shared package/header mem_ctrl_defs:
  - state encoding constants (3-bit): IDLE=0, ADDR=1, RD_WAIT=2, RD_CAP=3, RD_OUT=4, WR_DATA=5, WR_WAIT=6;
  - owner encoding: FETCH=0, DATA=1.
- Sub-module: rr_arb2, a 2-way round-robin arbiter with req[1:0], last, update inputs and a one-hot gnt[1:0] output. The FSM and latency counter stay in mem_access_ctrl.

Test Plan:
- Reset: hold reset 2 cycles with both requests high -> all outputs 0, busy=0. First grant after reset is fetch, because last_gnt=data.
- Fetch read, MEM_LAT=2, memory model returns Mdata=23:
  - cycle+1: MARin=1;
  - Read=1 for 2 cycles;
  - then MDRin=1 with Read=1;
  - then MDRout=1, bus=23, fetch_done=1 exactly 1 cycle, then busy=0.
- Store, data_req=1, data_we=1, bus data 35:
  - sequence ADDR -> WR_DATA (MDRin=1, Read=0) -> Write=1 for 2 cycles;
  - data_done on the second Write cycle;
  - memory model holds 35 at the MAR address.
- Contention: fetch_req and data_req held high continuously -> grants alternate fetch, data, fetch, data with no double grant. Read never overlaps Write.
- Reset mid-op: assert reset during RD_WAIT -> next cycle all outputs 0, state IDLE, no fetch_done. A new request is then served normally.
- MEM_LAT=1 build: read done exactly 4 cycles after the grant edge, store done 3 cycles after.
